// File: rtl/bdm_bit_engine.sv
// BDM byte engine: shifts one byte MSB-first on/off BKGD with sync-derived timing.
// Optional release speed-up pulse enabled by defining BDM_SPEEDUP_EN.
module bdm_bit_engine #(
  parameter int SPEEDUP_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] sync_length,
  input  logic        sync_length_is_ready,
  input  logic        bkgd_in,
  output logic        bkgd_oe,
  output logic        bkgd_out,
  input  logic        start_tx,
  input  logic [7:0]  tx_byte,
  input  logic        start_rx,
  output logic [7:0]  rx_byte,
  output logic        busy,
  output logic        done
);

`ifdef BDM_SPEEDUP_EN
  localparam bit SPD_EN = 1'b1;
`else
  localparam bit SPD_EN = 1'b0;
`endif
  localparam logic [29:0] SPD = 30'(SPEEDUP_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    BIT,
    DONE
  } state_t;

  state_t      state, state_nx;
  logic [25:0] tc, tc_nx;
  logic        is_tx, is_tx_nx;
  logic [7:0]  sh, sh_nx;
  logic [2:0]  bit_idx, bit_idx_nx;
  logic [29:0] cnt, cnt_nx;
  logic [7:0]  rx_nx;
  logic        busy_nx, done_nx;
  logic        oe_nx, out_nx;

  logic [31:0] sl_shift;
  logic [25:0] tc_new;
  logic [29:0] tcw, t4, t10, t13, t16;
  logic [29:0] low_len;

  assign sl_shift = sync_length >> 7;
  assign tc_new   = (sl_shift == 32'd0) ? 26'd1 : sl_shift[25:0];

  assign tcw = {4'd0, tc};
  assign t4  = tcw << 2;
  assign t10 = tcw * 30'd10;
  assign t13 = tcw * 30'd13;
  assign t16 = tcw << 4;

  // a zero bit is the only long low phase
  assign low_len = (is_tx && !sh[bit_idx]) ? t13 : t4;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      tc       <= 26'd1;
      is_tx    <= 1'b0;
      sh       <= 8'h00;
      bit_idx  <= 3'd0;
      cnt      <= 30'd0;
      rx_byte  <= 8'h00;
      busy     <= 1'b0;
      done     <= 1'b0;
      bkgd_oe  <= 1'b0;
      bkgd_out <= 1'b1;
    end else begin
      state    <= state_nx;
      tc       <= tc_nx;
      is_tx    <= is_tx_nx;
      sh       <= sh_nx;
      bit_idx  <= bit_idx_nx;
      cnt      <= cnt_nx;
      rx_byte  <= rx_nx;
      busy     <= busy_nx;
      done     <= done_nx;
      bkgd_oe  <= oe_nx;
      bkgd_out <= out_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    tc_nx      = tc;
    is_tx_nx   = is_tx;
    sh_nx      = sh;
    bit_idx_nx = bit_idx;
    cnt_nx     = cnt;
    rx_nx      = rx_byte;
    busy_nx    = 1'b0;
    done_nx    = 1'b0;
    oe_nx      = 1'b0;
    out_nx     = 1'b1;
    unique case (state)
      IDLE: begin
        if (sync_length_is_ready && (start_tx || start_rx)) begin
          state_nx   = BIT;
          tc_nx      = tc_new;
          is_tx_nx   = start_tx;
          bit_idx_nx = 3'd7;
          cnt_nx     = 30'd0;
          if (start_tx)
            sh_nx = tx_byte;
        end
      end
      BIT: begin
        busy_nx = 1'b1;
        if (cnt < low_len) begin
          oe_nx  = 1'b1;
          out_nx = 1'b0;
        end else if (SPD_EN && (cnt < low_len + SPD)) begin
          oe_nx  = 1'b1;
          out_nx = 1'b1;
        end
        if (!is_tx && (cnt == t10 - 30'd1))
          rx_nx = {rx_byte[6:0], bkgd_in};
        if (cnt == t16 - 30'd1) begin
          if (bit_idx == 3'd0) begin
            state_nx = DONE;
          end else begin
            bit_idx_nx = bit_idx - 3'd1;
            cnt_nx     = 30'd0;
          end
        end else begin
          cnt_nx = cnt + 30'd1;
        end
      end
      DONE: begin
        done_nx  = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_bdm_bit_engine.sv
// Bench for bdm_bit_engine: vector table, corner sequences, randomized bytes.
// Includes a simple BDM target that answers host-driven bit starts.
module tb_bdm_bit_engine;
  localparam int SPD = 2;
`ifdef BDM_SPEEDUP_EN
  localparam bit SPD_ON = 1'b1;
`else
  localparam bit SPD_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] sync_length = 32'd0;
  logic        sync_length_is_ready = 1'b1;
  logic        bkgd_in;
  logic        bkgd_oe;
  logic        bkgd_out;
  logic        start_tx = 1'b0;
  logic [7:0]  tx_byte = 8'h00;
  logic        start_rx = 1'b0;
  logic [7:0]  rx_byte;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;
  logic [7:0] model_rx = 8'h00;

  bdm_bit_engine #(.SPEEDUP_CYCLES(SPD)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .sync_length          (sync_length),
    .sync_length_is_ready (sync_length_is_ready),
    .bkgd_in              (bkgd_in),
    .bkgd_oe              (bkgd_oe),
    .bkgd_out             (bkgd_out),
    .start_tx             (start_tx),
    .tx_byte              (tx_byte),
    .start_rx             (start_rx),
    .rx_byte              (rx_byte),
    .busy                 (busy),
    .done                 (done)
  );

  always #5 clk = ~clk;

  // target: stretches each host low to 4*tc (1) or 13*tc (0)
  bit         tgt_en = 1'b0;
  logic [7:0] tgt_pat = 8'h00;
  int         tgt_tc = 1;
  int         tgt_hold = 0;
  int         tgt_n = 0;
  logic       host_low_d = 1'b0;
  logic       host_low;

  assign host_low = bkgd_oe & ~bkgd_out;
  assign bkgd_in  = ~(host_low | (tgt_hold > 0));

  always @(posedge clk) begin
    host_low_d <= host_low;
    if (!tgt_en) begin
      tgt_n    <= 0;
      tgt_hold <= 0;
    end else if (host_low && !host_low_d) begin
      tgt_hold <= (tgt_pat[7 - (tgt_n & 7)] ? 4 : 13) * tgt_tc;
      tgt_n    <= tgt_n + 1;
    end else if (tgt_hold > 0) begin
      tgt_hold <= tgt_hold - 1;
    end
  end

  task automatic check(input bit ok, input string name,
                       input longint act, input longint exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int tc_of(input logic [31:0] sl);
    int t;
    t = int'(sl >> 7);
    return (t == 0) ? 1 : t;
  endfunction

  task automatic run_byte(input bit tx, input bit both,
                          input logic [7:0] data, input logic [31:0] sl,
                          input int exp_lat, input logic [7:0] exp_rx,
                          input int poke);
    bit oe_q[$];
    bit out_q[$];
    bit busy_q[$];
    int tc, t16, done_at, n, bad, bb, post_bad;
    bit drv_tx;
    tc = tc_of(sl);
    t16 = 16 * tc;
    drv_tx = tx || both;
    done_at = -1;
    sync_length = sl;
    tx_byte = data;
    start_tx = drv_tx;
    start_rx = !tx || both;
    tgt_pat = data;
    tgt_tc = tc;
    tgt_en = !drv_tx;
    @(posedge clk);
    #1;
    start_tx = 1'b0;
    start_rx = 1'b0;
    sync_length = $urandom;
    tx_byte = ~data;
    for (int i = 1; i <= 8 * t16 + 20; i++) begin
      @(posedge clk);
      #1;
      start_tx = 1'b0;
      start_rx = 1'b0;
      oe_q.push_back(bkgd_oe);
      out_q.push_back(bkgd_out);
      busy_q.push_back(busy);
      if (done) begin
        done_at = i;
        break;
      end
      if (poke == i) begin
        start_tx = 1'b1;
        start_rx = 1'b1;
      end
    end
    tgt_en = 1'b0;
    check(done_at == exp_lat, "done latency", done_at, exp_lat);

    n = oe_q.size();
    bad = 0;
    for (int i = 1; i <= n; i++) begin
      int b, c, ll;
      bit bv, el, eh;
      el = 1'b0;
      eh = 1'b0;
      if (i <= 8 * t16) begin
        b = (i - 1) / t16;
        c = (i - 1) % t16;
        bv = drv_tx ? data[7 - b] : 1'b1;
        ll = bv ? 4 * tc : 13 * tc;
        el = c < ll;
        eh = SPD_ON && (c >= ll) && (c < ll + SPD);
      end
      if (oe_q[i-1] != (el | eh) || ((el | eh) && out_q[i-1] != eh))
        bad++;
    end
    check(bad == 0, "waveform bad cycles", bad, 0);

    bb = 0;
    for (int i = 1; i <= n; i++) begin
      if (i < n && !busy_q[i-1]) bb++;
      if (i == n && done_at > 0 && busy_q[i-1]) bb++;
    end
    check(bb == 0, "busy bad cycles", bb, 0);
    check(rx_byte === exp_rx, "rx_byte", rx_byte, exp_rx);

    post_bad = 0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (done || busy || bkgd_oe) post_bad++;
    end
    check(post_bad == 0, "idle after done", post_bad, 0);
  endtask

  typedef struct {
    bit          tx;
    bit          both;
    logic [7:0]  data;
    logic [31:0] sl;
    int          lat;
    logic [7:0]  rx;
    int          poke;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int bad;
    bit tx;
    logic [7:0] d;
    logic [31:0] sl;

    tbl[0] = '{1'b1, 1'b0, 8'hA5, 32'd1280, 1281, 8'h00, 0};
    tbl[1] = '{1'b0, 1'b0, 8'h3C, 32'd1280, 1281, 8'h3C, 0};
    tbl[2] = '{1'b1, 1'b0, 8'hFF, 32'd100,  129,  8'h3C, 0};
    tbl[3] = '{1'b1, 1'b1, 8'h5A, 32'd300,  257,  8'h3C, 0};
    tbl[4] = '{1'b1, 1'b0, 8'h00, 32'd127,  129,  8'h3C, 0};
    tbl[5] = '{1'b0, 1'b0, 8'hC3, 32'd255,  129,  8'hC3, 20};
    tbl[6] = '{1'b1, 1'b0, 8'h81, 32'd2047, 1921, 8'hC3, 50};

    repeat (3) @(posedge clk);
    #1;
    check(bkgd_oe == 1'b0, "reset bkgd_oe", bkgd_oe, 0);
    check(bkgd_out == 1'b1, "reset bkgd_out", bkgd_out, 1);
    check(busy == 1'b0, "reset busy", busy, 0);
    check(done == 1'b0, "reset done", done, 0);
    check(rx_byte == 8'h00, "reset rx_byte", rx_byte, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // not ready: start ignored
    sync_length = 32'd1280;
    sync_length_is_ready = 1'b0;
    start_tx = 1'b1;
    tx_byte = 8'h00;
    @(posedge clk);
    #1;
    start_tx = 1'b0;
    bad = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (busy || done || bkgd_oe) bad++;
    end
    check(bad == 0, "start gated by ready", bad, 0);
    sync_length_is_ready = 1'b1;

    for (int v = 0; v < 7; v++)
      run_byte(tbl[v].tx, tbl[v].both, tbl[v].data, tbl[v].sl,
               tbl[v].lat, tbl[v].rx, tbl[v].poke);
    model_rx = 8'hC3;

    // reset in the middle of bit 3 (tc=2, bit 3 starts at cycle 97)
    sync_length = 32'd256;
    tx_byte = 8'h0F;
    start_tx = 1'b1;
    @(posedge clk);
    #1;
    start_tx = 1'b0;
    repeat (99) @(posedge clk);
    #1;
    check(busy == 1'b1 && bkgd_oe == 1'b1, "mid-byte drive", bkgd_oe, 1);
    #2;
    rst = 1'b0;
    #1;
    check(bkgd_oe == 1'b0 && busy == 1'b0, "async release", bkgd_oe, 0);
    bad = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (done || busy || bkgd_oe) bad++;
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (done || busy || bkgd_oe) bad++;
    end
    check(bad == 0, "no done after reset", bad, 0);
    model_rx = 8'h00;
    check(rx_byte == model_rx, "rx_byte after reset", rx_byte, model_rx);
    run_byte(1'b1, 1'b0, 8'h01, 32'd256, 257, model_rx, 0);

    for (int r = 0; r < 12; r++) begin
      tx = 1'($urandom_range(0, 1));
      d = 8'($urandom);
      sl = 32'($urandom_range(0, 2000));
      if (!tx) model_rx = d;
      run_byte(tx, 1'b0, d, sl, 128 * tc_of(sl) + 1, model_rx, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bdm_bit_engine.md
# bdm_bit_engine

Byte-level BDM serial engine sitting directly downstream of the sync controller. It consumes the measured sync length (host clocks per 128 target cycles) and derives the target bit time from it. It then shifts one byte MSB-first onto, or off, the single-wire BKGD line using standard BDM bit timing. The command sequencer drives it one byte at a time with a start/done handshake.

## Interface
Parameters:
- SPEEDUP_CYCLES, 2: host clocks of active-high drive after each release; only used when BDM_SPEEDUP_EN is defined.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset (low = reset).
- sync_length  in  32  host clocks measured for the 128-target-cycle sync pulse.
- sync_length_is_ready  in  1  high when sync_length is stable; starts are gated on it.
- bkgd_in  in  1  synchronised BKGD pin level.
- bkgd_oe  out  1  1 = drive BKGD; 0 = release (pull-up).
- bkgd_out  out  1  level driven when bkgd_oe=1.
- start_tx  in  1  single-cycle request to transmit tx_byte.
- tx_byte  in  8  byte to send; sampled on the accepted start_tx.
- start_rx  in  1  single-cycle request to receive a byte.
- rx_byte  out  8  received byte; valid from done until the next accepted start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse at byte completion.

## Operation
- States: IDLE, BIT, DONE.
- Target cycle: tc = sync_length >> 7, latched at start. If the result is 0, tc = 1. Held in 26 bits.
- Derived counts are computed from the latched tc, not from the live input: t4=4·tc, t10=10·tc, t13=13·tc, t16=16·tc.
- Start acceptance:
  - Accepted only in IDLE with sync_length_is_ready=1.
  - Otherwise the request is ignored, with no error and no queueing.
  - If start_tx and start_rx are high together, TX wins.
- On accept:
  - Latch tc and mode, plus tx_byte for TX.
  - bit_idx=7, cnt=0. Go to BIT.
- BIT: cnt counts 0..t16−1 once per bit. The low phase lasts cycles 0..low_len−1 (bkgd_oe=1, bkgd_out=0); after that the line is released.
  - TX bit=1: low_len=t4.
  - TX bit=0: low_len=t13.
  - RX: low_len=t4. Sample bkgd_in at cnt==t10−1 and shift it into rx_byte at the LSB; the first-sampled bit ends as the MSB.
  - At cnt==t16−1: if bit_idx==0, go to DONE; else decrement bit_idx, reset cnt to 0 and continue.
- DONE: one cycle. Then return to IDLE. Starts in DONE are ignored.
- rx_byte updates only in RX mode. A TX byte leaves rx_byte unchanged.
- Reset values: state=IDLE, bkgd_oe=0, bkgd_out=1, busy=0, done=0, rx_byte=0x00.
- Reset mid-byte: the line is released immediately (async) and no done is produced.

## Timing
- Outputs are registered.
- Start sampled at edge k:
  - bkgd_oe=1 and busy=1 from edge k+1.
  - Bit n (0..7) low phase begins at edge k+1+n·t16.
- done=1 for exactly the cycle following edge k+1+8·t16; busy=0 in that same cycle.
- Total byte latency: 8·t16+1 clocks from start to done.
- Back-to-back bytes: the earliest next accept is the cycle after done (IDLE). The minimum inter-byte gap is 2 clocks.
- sync_length changes during a byte are ignored until the next start.

## Configuration
- BDM_SPEEDUP_EN defined:
  - On every low-to-release transition, drive bkgd_oe=1, bkgd_out=1 for SPEEDUP_CYCLES clocks, then release.
  - The pulse is truncated at the end of the bit period.
  - RX sampling is unaffected. This requires SPEEDUP_CYCLES < 6·tc; that is the user's responsibility.
- Undefined: bkgd_out only ever drives 0 while bkgd_oe=1; the release relies solely on the pull-up. SPEEDUP_CYCLES is unused.

## Test plan
- TX 0xA5, sync_length=1280 (tc=10):
  - Low pulses are 40,130,40,130,130,40,130,40 clocks, each period 160.
  - done pulses 1281 clocks after start; busy drops the same cycle.
- RX, sync_length=1280: the target model holds the line low for 130 clocks on 0 bits and 40 on 1 bits, pattern 0x3C → rx_byte=0x3C at done.
- sync_length=100 (tc clamps to 1):
  - TX 0xFF gives 8 low pulses of 4 clocks, period 16.
  - done at 129 clocks.
- Arbitration and gating:
  - start_tx and start_rx in the same cycle → TX performed, rx_byte unchanged.
  - Starts while busy, or while sync_length_is_ready=0, are ignored (no busy, no done).
- Reset mid-byte: assert rst low at bit 3 → bkgd_oe=0 immediately, no done. After release, a new TX 0x01 completes normally.
- BDM_SPEEDUP_EN, SPEEDUP_CYCLES=2, tc=10: each release is followed by exactly 2 clocks of bkgd_oe=1/bkgd_out=1. Without the macro, bkgd_out is never 1 while bkgd_oe=1.
